// File: rtl/addersub_pipe_pkg.sv
// ----------------------------------------------------------------------------
// addersub_pipe_pkg
//   Shared definitions for the pipelined add/sub/set-less-than unit.
//   - op_t and the OP_* encodings of the 3-bit op field {is_slt, signext, addsub}
//   - OP_IS_SLT / OP_SIGNEXT / OP_ADDSUB bit positions within op_t
//   - op_is_sub(): whether an op performs a subtraction
//   The stage payload struct lives in addersub_pipe because its result field
//   is sized by that module's WIDTH parameter.
// ----------------------------------------------------------------------------
package addersub_pipe_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_SUBU = 3'd0;
    localparam op_t OP_ADDU = 3'd1;
    localparam op_t OP_SUB  = 3'd2;
    localparam op_t OP_ADD  = 3'd3;
    localparam op_t OP_SLTU = 3'd4;
    localparam op_t OP_SLT  = 3'd6;

    localparam int unsigned OP_IS_SLT  = 2;
    localparam int unsigned OP_SIGNEXT = 1;
    localparam int unsigned OP_ADDSUB  = 0;

    // Set-less-than always compares via subtraction, whatever addsub says.
    function automatic logic op_is_sub(input op_t op);
        return op[OP_IS_SLT] | ~op[OP_ADDSUB];
    endfunction

endpackage

// File: rtl/addersub_core.sv
// ----------------------------------------------------------------------------
// addersub_core
//   Combinational add/sub/set-less-than datapath on WIDTH-bit operands.
//   Ports:
//     opA, opB    in   WIDTH  operands
//     op          in   3      {is_slt, signext, addsub}
//     result      out  WIDTH  sum/difference, or zero-extended less-than bit
//     result_slt  out  1      bit WIDTH of the extended sum
//     overflow    out  1      signed overflow, only for ADD/SUB
// ----------------------------------------------------------------------------
module addersub_core
    import addersub_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  op_t              op,
    output logic [WIDTH-1:0] result,
    output logic             result_slt,
    output logic             overflow
);

    logic             w_is_slt;
    logic             w_signext;
    logic             w_sub;
    logic [WIDTH:0]   w_ext_a;
    logic [WIDTH:0]   w_ext_b;
    logic [WIDTH:0]   w_opnd_b;
    logic [WIDTH:0]   w_sum;

    always_comb begin
        w_is_slt  = op[OP_IS_SLT];
        w_signext = op[OP_SIGNEXT];
        w_sub     = op_is_sub(op);

        // One extra bit lets bit WIDTH act as the signed or unsigned borrow.
        w_ext_a = {w_signext & opA[WIDTH-1], opA};
        w_ext_b = {w_signext & opB[WIDTH-1], opB};

        w_opnd_b = w_sub ? ~w_ext_b : w_ext_b;
        w_sum    = w_ext_a + w_opnd_b + {{WIDTH{1'b0}}, w_sub};

        result     = w_is_slt ? {{(WIDTH-1){1'b0}}, w_sum[WIDTH]} : w_sum[WIDTH-1:0];
        result_slt = w_sum[WIDTH];
        // Top two bits disagree exactly when the signed result left WIDTH bits.
        overflow   = w_signext & ~w_is_slt & (w_sum[WIDTH] ^ w_sum[WIDTH-1]);
    end

endmodule

// File: rtl/addersub_pipe.sv
// ----------------------------------------------------------------------------
// addersub_pipe
//   LATENCY-stage pipelined wrapper around addersub_core with valid/stall/flush.
//   Ports:
//     clk, resetn           clock, asynchronous active-low reset
//     in_valid              operands/op present this cycle
//     opA, opB, op          operands and op {is_slt, signext, addsub}
//     stall                 hold every stage (inputs not captured)
//     flush                 clear every stage valid; wins over stall
//     out_valid             result fields valid
//     result, result_slt    sum/difference (or SLT bit) and extended bit WIDTH
//     overflow              signed overflow for ADD/SUB
// ----------------------------------------------------------------------------
module addersub_pipe
    import addersub_pipe_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LATENCY = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  op_t              op,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             result_slt,
    output logic             overflow
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] result;
        logic             result_slt;
        logic             overflow;
    } stage_t;

    logic [WIDTH-1:0] w_core_result;
    logic             w_core_slt;
    logic             w_core_ovf;

    // w_stage[0] is the combinational payload; w_stage[i] is the output of stage i.
    stage_t           w_stage [LATENCY+1];

    addersub_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .opA        (opA),
        .opB        (opB),
        .op         (op),
        .result     (w_core_result),
        .result_slt (w_core_slt),
        .overflow   (w_core_ovf)
    );

    assign w_stage[0] = '{
        valid:      in_valid,
        result:     w_core_result,
        result_slt: w_core_slt,
        overflow:   w_core_ovf
    };

    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
        stage_t r_stage;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_stage <= '0;
            end else if (flush) begin
                // Data may go stale; only the valid matters once squashed.
                r_stage.valid <= 1'b0;
            end else if (!stall) begin
                r_stage <= w_stage[gi];
            end
        end

        assign w_stage[gi+1] = r_stage;
    end

    assign out_valid  = w_stage[LATENCY].valid;
    assign result     = w_stage[LATENCY].result;
    assign result_slt = w_stage[LATENCY].result_slt;
    assign overflow   = w_stage[LATENCY].overflow;

endmodule

// File: doc/addersub_pipe.md
Name: addersub_pipe

Overview:
- Parametrised, pipelined successor to the processor's add/sub/set-less-than unit.
- Performs ADDU, ADD, SUBU, SUB, SLTU and SLT on WIDTH-bit operands.
- Adds LATENCY register stages, a valid/stall/flush pipeline protocol, a signed-overflow flag for ADD/SUB, and a WIDTH-wide zero-extended SLT result.
- Sits in the execute stage, in place of the combinational adder, when timing requires a multicycle add path.

Parameters:
- WIDTH, 32, operand and result width (>=2)
- LATENCY, 1, number of register stages from operand capture to output (1..4)

Ports:
- clk  input  1  clock, all state on rising edge
- resetn  input  1  asynchronous active-low reset
- in_valid  input  1  operands/op present this cycle
- opA  input  WIDTH  operand A
- opB  input  WIDTH  operand B
- op  input  3  {is_slt, signext, addsub}: 0 SUBU, 2 SUB, 1 ADDU, 3 ADD, 4 SLTU, 6 SLT
- stall  input  1  freeze every pipeline stage
- flush  input  1  squash all in-flight operations
- out_valid  output  1  result fields valid this cycle
- result  output  WIDTH  sum/difference, or zero-extended SLT bit when is_slt
- result_slt  output  1  less-than bit, i.e. bit WIDTH of the (WIDTH+1)-bit extended difference
- overflow  output  1  signed overflow; asserted only for op 2 or 3

Behaviour:
- Reset: asynchronous on resetn low. All stage valids, out_valid, result, result_slt and overflow go to 0 immediately and stay 0 until the first capture after resetn rises.
- Arithmetic, computed combinationally at the input:
  - Extend each operand to WIDTH+1 bits, using bit WIDTH = signext & msb.
  - addsub=1: sum = eA + eB. addsub=0: sum = eA + ~eB + 1.
  - All arithmetic is modulo 2^(WIDTH+1).
- Output fields:
  - is_slt=1: result = {WIDTH-1 zeros, sum[WIDTH]}.
  - Otherwise: result = sum[WIDTH-1:0].
  - result_slt = sum[WIDTH] for all ops.
  - overflow = signext & ~is_slt & (sum[WIDTH] ^ sum[WIDTH-1]).
- Ops 5 and 7: is_slt forces subtraction, so they behave exactly as 4 and 6 respectively.
- Pipeline:
  - Stage 1 registers the computed fields plus in_valid.
  - Stages 2..LATENCY shift the fields forward.
  - Outputs are driven directly from the last stage.
  - Latency is exactly LATENCY cycles of non-stalled clocks. One new operation per cycle; no bubbles are inserted.
- Stall:
  - While stall=1, every stage holds its data and valid, and in_valid/operands are ignored (not captured).
  - out_valid remains asserted if it was, and consumers must not double-count it.
- Flush:
  - flush=1 clears every stage valid at the next edge, including an operation presented on the same cycle.
  - Flush has priority over stall.
  - Data registers may retain stale values; all outputs other than out_valid are don't-care while out_valid=0.
- Wrap-around: ADDU/SUBU wrap silently with no flag. ADD/SUB wrap and raise overflow; this block does not trap.
- Reset mid-operation: all in-flight operations are lost, and out_valid is 0 on the first cycle after release.

Decomposition:
- Shared package:
  - op encoding constants OP_SUBU=0, OP_ADDU=1, OP_SUB=2, OP_ADD=3, OP_SLTU=4, OP_SLT=6
  - bit-index constants OP_IS_SLT=2, OP_SIGNEXT=1, OP_ADDSUB=0
  - a packed stage-payload typedef {valid, result, result_slt, overflow}
- One sub-module: addersub_core.
  - Purely combinational, parameter WIDTH.
  - Inputs opA, opB, op; outputs result, result_slt, overflow.
  - Instantiated once ahead of the stage registers.
  - The pipe wrapper owns only the stage registers, stall/flush control and the LATENCY generate loop.

Test Plan (all with WIDTH=32):
- LATENCY=1, ADD 0x7FFFFFFF + 1, in_valid one cycle -> next cycle out_valid=1, result=0x80000000, overflow=1. The same operands with ADDU give overflow=0.
- LATENCY=2, SLT with opA=0xFFFFFFFF (-1), opB=1 -> after 2 cycles result=0x00000001, result_slt=1. SLTU with the same operands -> result=0, result_slt=0.
- LATENCY=3, back-to-back SUBU 5-3, SUB 0x80000000-1, ADDU 0xFFFFFFFF+1 on consecutive cycles -> outputs 0x2 (ovf 0), 0x7FFFFFFF (ovf 1), 0x0 (ovf 0) on three consecutive cycles starting at cycle 3.
- LATENCY=2, issue ADDU 1+2, then stall=1 for 3 cycles starting the next cycle -> out_valid and result=3 appear only after stall drops; ops offered during the stall are not captured.
- LATENCY=3, two ops in flight, assert flush together with stall and a new in_valid -> out_valid stays 0 for the following 4 cycles.
- LATENCY=2, drop resetn asynchronously between edges with a valid op in flight -> out_valid/result go to 0 before the next edge, and the op never emerges after release.
